// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory read arbiter.
// Provides FSM state, grant encoding and AXI protection/response codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_e;

  localparam logic [2:0] PROT_INSTR = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// AXI-style read channel (AR + R) between the arbiter and memory.
// master: arbiter side (drives AR*, RREADY); slave: memory side.
interface mem_read_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              RVALID;
  logic              RREADY;
  logic              RLAST;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  ARREADY, RVALID, RLAST, RDATA, RRESP
  );

  modport slave (
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output ARREADY, RVALID, RLAST, RDATA, RRESP
  );

endinterface

// File: rtl/mem_read_arbiter_rr_arbiter2.sv
// Two-requester arbiter (IF vs LS), fixed-LS or round-robin mode.
// Ports: clk, rst_n, req_if, req_ls, upd (commit grant), gnt.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_if,
  input  logic   req_ls,
  input  logic   upd,
  output grant_e gnt
);

  grant_e last_q;
  grant_e last_d;

  always_comb begin
    gnt    = GNT_LS;
    last_d = last_q;
    if (req_if && !req_ls) begin
      gnt = GNT_IF;
    end else if (req_ls && !req_if) begin
      gnt = GNT_LS;
    end else if (FIXED_PRIO != 0) begin
      gnt = GNT_LS;
    end else begin
      // Collision: favour whoever did not win last time.
      gnt = (last_q == GNT_IF) ? GNT_LS : GNT_IF;
    end
    if (upd) begin
      last_d = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= GNT_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Serialises IF and LS level read requests onto one AXI read port.
// Ports: ACLK/ARESETn, if_* and ls_* requester sides, axi master.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIXED_PRIO = 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_en,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  mem_read_arbiter_if.master axi
);

  state_e            state_q, state_d;
  grant_e            gnt_q, gnt_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic              rready_q, rready_d;
  logic              sticky_q, sticky_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic              ls_valid_q, ls_valid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              ls_err_q, ls_err_d;

  logic   arb_upd;
  grant_e arb_gnt;
  logic   beat_err;
  logic   fin_err;

  rr_arbiter2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .req_if(if_en),
    .req_ls(ls_en),
    .upd   (arb_upd),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arprot_d   = arprot_q;
    rready_d   = rready_q;
    sticky_d   = sticky_q;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    if_err_d   = if_err_q;
    ls_valid_d = 1'b0;
    ls_rdata_d = ls_rdata_q;
    ls_err_d   = ls_err_q;
    arb_upd    = 1'b0;
    beat_err   = (axi.RRESP != RESP_OKAY);
    fin_err    = sticky_q | beat_err;

    unique case (state_q)
      IDLE: begin
        if (if_en || ls_en) begin
          arb_upd   = 1'b1;
          gnt_d     = arb_gnt;
          arvalid_d = 1'b1;
          state_d   = ADDR;
          if (arb_gnt == GNT_LS) begin
            araddr_d = ls_addr;
            arprot_d = PROT_DATA;
          end else begin
            araddr_d = if_addr;
            arprot_d = PROT_INSTR;
          end
        end
      end
      ADDR: begin
        if (axi.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (axi.RVALID) begin
          if (gnt_q == GNT_LS) begin
            ls_rdata_d = axi.RDATA;
          end else begin
            if_rdata_d = axi.RDATA;
          end
          if (axi.RLAST) begin
            // Error and valid are registered here so they
            // appear together during RESP.
            rready_d = 1'b0;
            sticky_d = 1'b0;
            state_d  = RESP;
            if (gnt_q == GNT_LS) begin
              ls_valid_d = 1'b1;
              ls_err_d   = fin_err;
            end else begin
              if_valid_d = 1'b1;
              if_err_d   = fin_err;
            end
          end else begin
            sticky_d = fin_err;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arprot_q   <= '0;
      rready_q   <= 1'b0;
      sticky_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ls_valid_q <= 1'b0;
      ls_rdata_q <= '0;
      ls_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arprot_q   <= arprot_d;
      rready_q   <= rready_d;
      sticky_q   <= sticky_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      ls_valid_q <= ls_valid_d;
      ls_rdata_q <= ls_rdata_d;
      ls_err_q   <= ls_err_d;
    end
  end

  assign axi.ARVALID = arvalid_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARPROT  = arprot_q;
  assign axi.RREADY  = rready_q;
  assign if_valid    = if_valid_q;
  assign if_rdata    = if_rdata_q;
  assign if_err      = if_err_q;
  assign ls_valid    = ls_valid_q;
  assign ls_rdata    = ls_rdata_q;
  assign ls_err      = ls_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: fixed-priority and
// round-robin instances, table vectors plus corner sequences.
module tb_mem_read_arbiter;

  logic        ACLK;
  logic        ARESETn;

  logic        if_en, ls_en;
  logic [31:0] if_addr, ls_addr;
  logic        if_valid, ls_valid;
  logic [63:0] if_rdata, ls_rdata;
  logic        if_err, ls_err;

  logic        ARREADY, RVALID, RLAST;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;

  logic        rr_if_en, rr_ls_en;
  logic        rr_if_valid, rr_ls_valid;
  logic [63:0] rr_if_rdata, rr_ls_rdata;
  logic        rr_if_err, rr_ls_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_if_rdata;
  logic [63:0] exp_ls_rdata;

  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(64)) axi ();
  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(64)) axi_rr ();

  assign axi.ARREADY = ARREADY;
  assign axi.RVALID  = RVALID;
  assign axi.RLAST   = RLAST;
  assign axi.RDATA   = RDATA;
  assign axi.RRESP   = RRESP;

  // Always-ready single-beat slave for the round-robin instance.
  assign axi_rr.ARREADY = 1'b1;
  assign axi_rr.RVALID  = 1'b1;
  assign axi_rr.RLAST   = 1'b1;
  assign axi_rr.RDATA   = 64'h55;
  assign axi_rr.RRESP   = 2'b00;

  mem_read_arbiter #(
    .ADDR_W(32), .DATA_W(64), .FIXED_PRIO(1)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .if_en(if_en), .if_addr(if_addr),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .if_err(if_err),
    .ls_en(ls_en), .ls_addr(ls_addr),
    .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .axi(axi.master)
  );

  mem_read_arbiter #(
    .ADDR_W(32), .DATA_W(64), .FIXED_PRIO(0)
  ) dut_rr (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .if_en(rr_if_en), .if_addr(32'h0000_1000),
    .if_valid(rr_if_valid), .if_rdata(rr_if_rdata),
    .if_err(rr_if_err),
    .ls_en(rr_ls_en), .ls_addr(32'h0000_2000),
    .ls_valid(rr_ls_valid), .ls_rdata(rr_ls_rdata),
    .ls_err(rr_ls_err),
    .axi(axi_rr.master)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        if_en;
    logic        ls_en;
    logic [31:0] if_addr;
    logic [31:0] ls_addr;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_addr;
    logic [2:0]  exp_prot;
    logic        exp_ls;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_arvalid"}, 64'(axi.ARVALID), 64'd0);
    chk({nm, "_araddr"}, 64'(axi.ARADDR), 64'd0);
    chk({nm, "_arprot"}, 64'(axi.ARPROT), 64'd0);
    chk({nm, "_rready"}, 64'(axi.RREADY), 64'd0);
    chk({nm, "_if_valid"}, 64'(if_valid), 64'd0);
    chk({nm, "_ls_valid"}, 64'(ls_valid), 64'd0);
    chk({nm, "_if_rdata"}, if_rdata, 64'd0);
    chk({nm, "_ls_rdata"}, ls_rdata, 64'd0);
    chk({nm, "_if_err"}, 64'(if_err), 64'd0);
    chk({nm, "_ls_err"}, 64'(ls_err), 64'd0);
  endtask

  // One single-beat transaction with an immediate slave.
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    ARREADY = 1'b1;
    RVALID  = 1'b1;
    RLAST   = 1'b1;
    RDATA   = v.rdata;
    RRESP   = v.rresp;
    if_en   = v.if_en;
    ls_en   = v.ls_en;
    if_addr = v.if_addr;
    ls_addr = v.ls_addr;
    step();
    chk({p, "_arvalid"}, 64'(axi.ARVALID), 64'd1);
    chk({p, "_araddr"}, 64'(axi.ARADDR), 64'(v.exp_addr));
    chk({p, "_arprot"}, 64'(axi.ARPROT), 64'(v.exp_prot));
    chk({p, "_rready0"}, 64'(axi.RREADY), 64'd0);
    step();
    chk({p, "_arvalid0"}, 64'(axi.ARVALID), 64'd0);
    chk({p, "_rready1"}, 64'(axi.RREADY), 64'd1);
    step();
    if (v.exp_ls) exp_ls_rdata = v.rdata;
    else          exp_if_rdata = v.rdata;
    chk({p, "_if_valid"}, 64'(if_valid), 64'(!v.exp_ls));
    chk({p, "_ls_valid"}, 64'(ls_valid), 64'(v.exp_ls));
    chk({p, "_if_rdata"}, if_rdata, exp_if_rdata);
    chk({p, "_ls_rdata"}, ls_rdata, exp_ls_rdata);
    if (v.exp_ls) chk({p, "_ls_err"}, 64'(ls_err), 64'(v.exp_err));
    else          chk({p, "_if_err"}, 64'(if_err), 64'(v.exp_err));
    if_en  = 1'b0;
    ls_en  = 1'b0;
    RVALID = 1'b0;
    step();
    chk({p, "_if_pulse"}, 64'(if_valid), 64'd0);
    chk({p, "_ls_pulse"}, 64'(ls_valid), 64'd0);
  endtask

  int order[4];
  int exp_order[4];
  int n_done;
  int cyc;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,
                64'h0000_0013_0000_0297, 2'b00,
                32'h8000_0000, 3'b100, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_1000,
                64'hDEAD_BEEF_CAFE_F00D, 2'b00,
                32'h8000_1000, 3'b000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_2000,
                64'h1111_2222_3333_4444, 2'b00,
                32'h8000_2000, 3'b000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h8000_2008,
                64'hA5A5_A5A5_5A5A_5A5A, 2'b10,
                32'h8000_2008, 3'b000, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,
                64'h0123_4567_89AB_CDEF, 2'b11,
                32'h8000_0010, 3'b100, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0014, 32'h0,
                64'hFEDC_BA98_7654_3210, 2'b00,
                32'h8000_0014, 3'b100, 1'b0, 1'b0};

    exp_order[0] = 1;
    exp_order[1] = 0;
    exp_order[2] = 1;
    exp_order[3] = 0;

    ARESETn  = 1'b0;
    if_en    = 1'b0;
    ls_en    = 1'b0;
    if_addr  = '0;
    ls_addr  = '0;
    ARREADY  = 1'b0;
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    RDATA    = '0;
    RRESP    = '0;
    rr_if_en = 1'b0;
    rr_ls_en = 1'b0;
    exp_if_rdata = '0;
    exp_ls_rdata = '0;

    step();
    step();
    chk_all_zero("rst");
    ARESETn = 1'b1;
    step();

    // Round-robin: both requesters keep asking.
    rr_if_en = 1'b1;
    rr_ls_en = 1'b1;
    n_done = 0;
    cyc = 0;
    while (n_done < 4 && cyc < 80) begin
      step();
      cyc++;
      if (rr_ls_valid && n_done < 4) begin
        order[n_done] = 1;
        n_done++;
      end
      if (rr_if_valid && n_done < 4) begin
        order[n_done] = 0;
        n_done++;
      end
      rr_ls_en = !rr_ls_valid;
      rr_if_en = !rr_if_valid;
    end
    rr_if_en = 1'b0;
    rr_ls_en = 1'b0;
    chk("rr_count", 64'(n_done), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_done)
        chk($sformatf("rr_order%0d", i),
            64'(order[i]), 64'(exp_order[i]));
    end
    step();
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Collision: LS first, then the still-held IF request.
    if_addr = 32'h8000_0000;
    ls_addr = 32'h8000_1000;
    if_en   = 1'b1;
    ls_en   = 1'b1;
    ARREADY = 1'b1;
    RVALID  = 1'b1;
    RLAST   = 1'b1;
    RRESP   = 2'b00;
    RDATA   = 64'hAAAA_0000_0000_0001;
    step();
    chk("col_addr1", 64'(axi.ARADDR), 64'h8000_1000);
    chk("col_prot1", 64'(axi.ARPROT), 64'd0);
    step();
    step();
    chk("col_ls_valid", 64'(ls_valid), 64'd1);
    chk("col_if_valid0", 64'(if_valid), 64'd0);
    chk("col_ls_rdata", ls_rdata, 64'hAAAA_0000_0000_0001);
    chk("col_arvalid3", 64'(axi.ARVALID), 64'd0);
    ls_en = 1'b0;
    RDATA = 64'hBBBB_0000_0000_0002;
    step();
    chk("col_arvalid4", 64'(axi.ARVALID), 64'd0);
    step();
    chk("col_arvalid5", 64'(axi.ARVALID), 64'd1);
    chk("col_addr2", 64'(axi.ARADDR), 64'h8000_0000);
    chk("col_prot2", 64'(axi.ARPROT), 64'h4);
    step();
    step();
    chk("col_if_valid", 64'(if_valid), 64'd1);
    chk("col_ls_valid0", 64'(ls_valid), 64'd0);
    chk("col_if_rdata", if_rdata, 64'hBBBB_0000_0000_0002);
    exp_ls_rdata = 64'hAAAA_0000_0000_0001;
    exp_if_rdata = 64'hBBBB_0000_0000_0002;
    if_en  = 1'b0;
    RVALID = 1'b0;
    step();

    // AR stall: ARREADY low for three cycles.
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    ls_en   = 1'b1;
    ls_addr = 32'h8000_3000;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("stall_arvalid%0d", k),
          64'(axi.ARVALID), 64'd1);
      chk($sformatf("stall_araddr%0d", k),
          64'(axi.ARADDR), 64'h8000_3000);
      chk($sformatf("stall_rready%0d", k),
          64'(axi.RREADY), 64'd0);
      if (k == 4) ARREADY = 1'b1;
    end
    step();
    chk("stall_arvalid_done", 64'(axi.ARVALID), 64'd0);
    chk("stall_rready1", 64'(axi.RREADY), 64'd1);
    ARREADY = 1'b0;
    RVALID  = 1'b1;
    RLAST   = 1'b1;
    RDATA   = 64'h3333;
    step();
    chk("stall_ls_valid", 64'(ls_valid), 64'd1);
    chk("stall_ls_rdata", ls_rdata, 64'h3333);
    exp_ls_rdata = 64'h3333;
    ls_en  = 1'b0;
    RVALID = 1'b0;
    step();

    // Four beats, error on beat 2, last beat delivered.
    ls_en   = 1'b1;
    ls_addr = 32'h8000_4000;
    ARREADY = 1'b1;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    step();
    step();
    RVALID = 1'b1;
    RDATA  = 64'd1;
    RRESP  = 2'b00;
    step();
    chk("mb_no_early_valid", 64'(ls_valid), 64'd0);
    RDATA = 64'd2;
    RRESP = 2'b10;
    step();
    RDATA = 64'd3;
    RRESP = 2'b00;
    step();
    RDATA = 64'd4;
    RLAST = 1'b1;
    step();
    chk("mb_ls_valid", 64'(ls_valid), 64'd1);
    chk("mb_ls_rdata", ls_rdata, 64'd4);
    chk("mb_ls_err", 64'(ls_err), 64'd1);
    exp_ls_rdata = 64'd4;
    ls_en  = 1'b0;
    RVALID = 1'b0;
    step();
    run_vec('{1'b0, 1'b1, 32'h0, 32'h8000_4008,
              64'h7777, 2'b00,
              32'h8000_4008, 3'b000, 1'b1, 1'b0}, 10);

    // Reset while in DATA, then stray beats before new work.
    ls_en   = 1'b1;
    ls_addr = 32'h8000_5000;
    ARREADY = 1'b1;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    step();
    step();
    chk("rd_in_data", 64'(axi.RREADY), 64'd1);
    ARESETn = 1'b0;
    ls_en   = 1'b0;
    step();
    chk_all_zero("midrst");
    exp_if_rdata = '0;
    exp_ls_rdata = '0;
    ARESETn = 1'b1;
    RVALID  = 1'b1;
    RLAST   = 1'b1;
    RDATA   = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stray_rready%0d", k),
          64'(axi.RREADY), 64'd0);
      chk($sformatf("stray_ifv%0d", k),
          64'(if_valid), 64'd0);
      chk($sformatf("stray_lsd%0d", k), ls_rdata, 64'd0);
    end
    run_vec('{1'b1, 1'b0, 32'h8000_0100, 32'h0,
              64'h0000_0000_1234_5678, 2'b00,
              32'h8000_0100, 3'b100, 1'b0, 1'b0}, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
